// File: rtl/clkdiv_multi_if.sv
// Configuration port of clkdiv_multi.
// A requester (master) offers {cfg_ch, cfg_div, cfg_en} with cfg_valid.
// The divider (slave) answers with cfg_ready and a one-cycle cfg_err pulse.
//   cfg_valid  m->s  request valid
//   cfg_ready  s->m  pending slot of channel cfg_ch is free
//   cfg_ch     m->s  target channel index
//   cfg_div    m->s  requested divisor
//   cfg_en     m->s  requested channel enable
//   cfg_err    s->m  request was rejected (registered, one cycle)
interface clkdiv_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel counts 0..D-1 and produces a registered square wave
// (D-H cycles low, H = floor(D/2) cycles high) plus a one-cycle tick in the
// cycle after the count wraps. New divisor/enable values are parked in a
// per-channel pending slot and only loaded at a period boundary, so the
// outputs never glitch.
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   reset_n     asynchronous active-low reset
//   sync_pulse  (CLKDIV_SYNC_EN only) restart every enabled channel at cnt 0
//   cfg         clkdiv_multi_if.slave configuration port
//   clk_out     divided clocks, registered
//   tick        one-cycle strobe per period, registered
//   busy        channel holds a configuration not yet applied
//
// Optional feature macro: CLKDIV_SYNC_EN (adds sync_pulse). Default build
// has no sync input and channels align only through reset.
module clkdiv_multi #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10,
  parameter int RESET_EN    = 1
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_pulse,
`endif
  clkdiv_multi_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic             EN_RST  = (RESET_EN != 0);

  logic              sync_w;
  logic [NUM_CH-1:0] ch_hit;
  logic              ready_c;
  logic              xfer;
  logic              bad_req;
  logic              err_d, err_q;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_pulse;
`else
  assign sync_w = 1'b0;
`endif

  // Channel decode; an out-of-range index hits no channel and is always
  // ready so that it can be accepted and flagged as an error.
  always_comb begin
    ch_hit  = '0;
    ready_c = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ch_hit[i] = 1'b1;
        ready_c   = ~busy[i];
      end
    end
  end

  assign cfg.cfg_ready = ready_c;
  assign xfer          = cfg.cfg_valid & ready_c;
  assign bad_req       = ~(|ch_hit) | ((cfg.cfg_div < DIV_W'(2)) & cfg.cfg_en);

  always_comb begin
    err_d = xfer & bad_req;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic [DIV_W-1:0] pdiv_d, pdiv_q;
    logic             en_d, en_q;
    logic             pen_d, pen_q;
    logic             pend_d, pend_q;
    logic             clk_d, clk_q;
    logic             tick_d, tick_q;
    logic             wrap;
    logic             apply;
    logic             take;

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pdiv_d = pdiv_q;
      en_d   = en_q;
      pen_d  = pen_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;

      // div_q is always >= 2 while enabled, so div_q-1 cannot underflow here.
      wrap  = en_q && (cnt_q == div_q - DIV_W'(1));
      apply = pend_q && (wrap || !en_q || sync_w);
      // A transfer only happens when the slot is empty, so take and a
      // pending apply never refer to the same request.
      take  = xfer && ch_hit[g] && !bad_req;

      if (en_q) begin
        cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
        tick_d = wrap;
      end

      if (apply) begin
        pend_d = 1'b0;
        en_d   = pen_q;
        cnt_d  = '0;
        if (pen_q) begin
          div_d = pdiv_q;
        end
      end

      if (sync_w && en_q) begin
        cnt_d  = '0;
        tick_d = 1'b0;
      end

      if (take) begin
        pend_d = 1'b1;
        pdiv_d = cfg.cfg_div;
        pen_d  = cfg.cfg_en;
      end

      // High for the last floor(D/2) counts of the period.
      clk_d = en_d && (cnt_d >= (div_d - (div_d >> 1)));
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        pdiv_q <= DIV_RST;
        en_q   <= EN_RST;
        pen_q  <= 1'b0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pdiv_q <= pdiv_d;
        en_q   <= en_d;
        pen_q  <= pen_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign busy[g]    = pend_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;
  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int CHW = 2;

  logic           clk_100MHz = 1'b0;
  logic           reset_n    = 1'b0;
`ifdef CLKDIV_SYNC_EN
  logic           sync_pulse = 1'b0;
`endif
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  clkdiv_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg ();

  clkdiv_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(10), .RESET_EN(1)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync_pulse (sync_pulse),
`endif
    .cfg        (cfg),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  // Hand model of each channel: period start edge, divisor, enable.
  int   base[NCH];
  int   dv[NCH];
  logic en_m[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    e++;
    #1;
  endtask

  task automatic check_chans(input string tag);
    for (int c = 0; c < NCH; c++) begin
      int k;
      int cnt;
      logic ec;
      logic et;
      k   = e - base[c];
      cnt = k % dv[c];
      ec  = en_m[c] && (cnt >= dv[c] - dv[c] / 2);
      et  = en_m[c] && (k > 0) && (cnt == 0);
      chk($sformatf("%s clk%0d", tag, c), 32'(clk_out[c]), 32'(ec));
      chk($sformatf("%s tick%0d", tag, c), 32'(tick[c]), 32'(et));
    end
  endtask

  task automatic drive(input int ch, input int d, input logic en);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = CHW'(ch);
    cfg.cfg_div   = DW'(d);
    cfg.cfg_en    = en;
    #1;
  endtask

  task automatic model_reset();
    e = 0;
    for (int c = 0; c < NCH; c++) begin
      base[c] = 0;
      dv[c]   = 10;
      en_m[c] = 1'b1;
    end
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_div   = '0;
    cfg.cfg_en    = 1'b0;
    model_reset();
    #2;
    chk("rst clk_out", 32'(clk_out), 32'd0);
    chk("rst tick", 32'(tick), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(cfg.cfg_err), 32'd0);
    chk("rst ready", 32'(cfg.cfg_ready), 32'd1);
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;

    // Free-running default D=10 on all channels.
    repeat (20) begin step(); check_chans("free"); end

    // ch0 -> D=4 requested at cnt=3; current period finishes first.
    repeat (3) begin step(); check_chans("pre4"); end
    drive(0, 4, 1'b1);
    chk("div4 ready", 32'(cfg.cfg_ready), 32'd1);
    step(); check_chans("div4 xfer");
    chk("div4 busy0", 32'(busy[0]), 32'd1);
    chk("div4 busy1", 32'(busy[1]), 32'd0);
    cfg.cfg_valid = 1'b0;
    repeat (5) begin step(); check_chans("div4 wait"); chk("div4 busy0 hold", 32'(busy[0]), 32'd1); end
    step(); check_chans("div4 wrap");
    chk("div4 busy0 clr", 32'(busy[0]), 32'd0);
    base[0] = e; dv[0] = 4;
    repeat (8) begin step(); check_chans("div4 run"); end

    // ch1 -> D=7, then a second request stalls while busy.
    drive(1, 7, 1'b1);
    chk("div7 ready", 32'(cfg.cfg_ready), 32'd1);
    step(); check_chans("div7 xfer");
    chk("div7 busy1", 32'(busy[1]), 32'd1);
    cfg.cfg_div = DW'(5);
    #1;
    chk("stall ready", 32'(cfg.cfg_ready), 32'd0);
    step(); check_chans("div7 wrap");
    chk("div7 busy1 clr", 32'(busy[1]), 32'd0);
    chk("stall ready back", 32'(cfg.cfg_ready), 32'd1);
    base[1] = e; dv[1] = 7;
    step(); check_chans("div5 xfer");
    chk("div5 busy1", 32'(busy[1]), 32'd1);
    cfg.cfg_valid = 1'b0;
    repeat (5) begin step(); check_chans("div7 run"); chk("div5 busy1 hold", 32'(busy[1]), 32'd1); end
    step(); check_chans("div7 end");
    chk("div5 busy1 clr", 32'(busy[1]), 32'd0);
    base[1] = e; dv[1] = 5;
    repeat (10) begin step(); check_chans("div5 run"); end

    // Rejected requests: D=1 with enable, and out-of-range channel.
    drive(0, 1, 1'b1);
    step(); check_chans("err div1");
    chk("err div1 pulse", 32'(cfg.cfg_err), 32'd1);
    chk("err div1 busy0", 32'(busy[0]), 32'd0);
    cfg.cfg_valid = 1'b0;
    step(); check_chans("err div1 after");
    chk("err div1 end", 32'(cfg.cfg_err), 32'd0);
    drive(3, 4, 1'b1);
    step(); check_chans("err ch3");
    chk("err ch3 pulse", 32'(cfg.cfg_err), 32'd1);
    chk("err ch3 busy", 32'(busy), 32'd0);
    cfg.cfg_valid = 1'b0;
    step(); check_chans("err ch3 after");
    chk("err ch3 end", 32'(cfg.cfg_err), 32'd0);

    // ch0 disable, transferred on its own wrap edge -> applies next wrap.
    drive(0, 0, 1'b0);
    step(); check_chans("dis xfer");
    chk("dis busy0", 32'(busy[0]), 32'd1);
    cfg.cfg_valid = 1'b0;
    repeat (3) begin step(); check_chans("dis wait"); chk("dis busy0 hold", 32'(busy[0]), 32'd1); end
    step();
    chk("dis clk0", 32'(clk_out[0]), 32'd0);
    chk("dis busy0 clr", 32'(busy[0]), 32'd0);
    en_m[0] = 1'b0;
    repeat (4) begin step(); check_chans("dis hold"); end

    // Re-enable ch0 with D=6; applies on the next edge.
    drive(0, 6, 1'b1);
    step(); check_chans("en xfer");
    chk("en busy0", 32'(busy[0]), 32'd1);
    cfg.cfg_valid = 1'b0;
    step();
    chk("en busy0 clr", 32'(busy[0]), 32'd0);
    base[0] = e; dv[0] = 6; en_m[0] = 1'b1;
    check_chans("en apply");
    repeat (12) begin step(); check_chans("en run"); end

`ifdef CLKDIV_SYNC_EN
    sync_pulse = 1'b1;
    step();
    sync_pulse = 1'b0;
    for (int c = 0; c < NCH; c++) base[c] = e;
    check_chans("sync edge");
    repeat (10) begin step(); check_chans("sync run"); end
`endif

    // Reset mid-period drops a pending request.
    drive(1, 9, 1'b1);
    step();
    chk("rst2 busy1", 32'(busy[1]), 32'd1);
    cfg.cfg_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst2 clk_out", 32'(clk_out), 32'd0);
    chk("rst2 tick", 32'(tick), 32'd0);
    chk("rst2 busy", 32'(busy), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (12) begin step(); check_chans("rst2 run"); end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Multi-channel programmable clock divider/enable generator driven from the board 100 MHz clock.
- Each channel produces a divided square wave and a one-cycle tick strobe.
- Divisors and enables are reconfigurable at runtime through a valid/ready port.
- Changes take effect only at period boundaries, so outputs never glitch.
- Feeds processor, peripheral and display timing domains.

Parameters:
- NUM_CH, 2, number of independent output channels (1..16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 10, divisor loaded into every channel at reset (100 MHz / 10 = 10 MHz)
- RESET_EN, 1, channel enable state at reset (1 = running)

Ports:
- clk_100MHz  in  1  system clock, all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration request valid
- cfg_ready  out  1  configuration slot free for the channel selected by cfg_ch
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel index
- cfg_div  in  DIV_W  requested divisor D
- cfg_en  in  1  requested channel enable
- cfg_err  out  1  one-cycle pulse when a request is rejected
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle strobe per period, registered
- busy  out  NUM_CH  channel has a pending configuration not yet applied

Behaviour:
- Reset (reset_n low, asynchronous):
  - cnt = 0, div_active = DEFAULT_DIV, en = RESET_EN, pending slot empty.
  - clk_out = 0, tick = 0, busy = 0, cfg_err = 0.
- Per-channel counter:
  - While enabled, cnt steps 0..D-1 and wraps to 0. Let H = floor(D/2).
  - clk_out_reg <= (cnt_next >= D-H), giving D-H cycles low then H cycles high; period D.
  - tick_reg <= 1 in the cycle after cnt == D-1 (coincides with the clk_out fall); 0 otherwise.
  - D = 10: clk_out rises after the 5th edge following reset release, falls after the 10th; tick is high for the cycle after the 10th edge.
- Handshake:
  - cfg_ready = ~busy[cfg_ch] (combinational on cfg_ch).
  - A transfer occurs when cfg_valid & cfg_ready on a rising edge; cfg_valid held without ready stalls, with no side effects.
  - cfg_ch >= NUM_CH, or cfg_div < 2 with cfg_en = 1: request accepted, discarded, cfg_err pulses 1 cycle, no state change.
  - Valid request: stored in the channel's pending slot; busy = 1 from the next cycle.
- Application:
  - Running channel: pending values load on the wrap edge (cnt == D-1 -> 0). The new divisor governs the period starting at cnt = 0; busy clears on that same edge.
  - Disabled channel: pending values apply on the next edge.
  - Disable request (cfg_en = 0): takes effect at the wrap. cnt is then held at 0, clk_out held 0, tick held 0; cfg_div is ignored.
  - Enable of a disabled channel: counting starts at cnt = 0 on the application edge.
- Boundaries:
  - D = 2 gives a 1-low/1-high clock.
  - D = 2^DIV_W-1 is legal; cnt never exceeds D-1, and no arithmetic overflows DIV_W.
  - Request arriving on the same edge as that channel's wrap: captured into pending, applied at the following wrap. It never applies mid-period.
  - reset_n asserted mid-period: immediate return to reset values; pending is dropped.
- Channels are fully independent; simultaneous wraps on multiple channels are all honoured.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- With it: extra input sync_pulse (1 bit). When high on a rising edge, every enabled channel forces cnt = 0, clk_out = 0 and tick = 0, phase-aligning all channels. Pending configurations also apply on that edge.
  - sync_pulse coincident with a cfg transfer: the transfer is captured and applied at the next wrap or sync.
- Without it: no sync_pulse port; channels align only through reset.

Test Plan:
- Release reset, no cfg -> each clk_out period is 10 cycles, 5 low/5 high; tick high once per 10 cycles, first after the 10th edge.
- Ch0 cfg_div = 4 mid-period (cnt = 3 of 10) -> current 10-cycle period completes unchanged, then period 4 (2/2); busy[0] high from the cycle after transfer until the wrap; ch1 unaffected.
- Ch1 cfg_div = 7 -> 4 low/3 high; a second request while busy[1] = 1 sees cfg_ready = 0 and is stalled until busy clears.
- cfg_div = 1, cfg_en = 1 on ch0, and cfg_ch = NUM_CH -> cfg_err pulses one cycle each time; no change in ch0 timing.
- Ch0 cfg_en = 0 then cfg_en = 1 with D = 6 -> clk_out stays 0 from the wrap; on re-enable, rises exactly 3 cycles after the application edge.
- Under CLKDIV_SYNC_EN: ch0 D = 4, ch1 D = 6, sync_pulse at an arbitrary cycle -> both clk_out low with cnt = 0 next cycle; ch0/ch1 rise 2 and 3 cycles later respectively.
